// File: rtl/bcd_countdown_mmss.sv
// bcd_countdown_mmss: preset BCD mm:ss down-counter with run/pause/done control,
// combinational borrow-out and registered done/err pulses.
module bcd_countdown_mmss #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] data,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] qout,
    output logic [1:0]  state,
    output logic        bout,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
    state_t      r_state;
    logic [15:0] r_q;
    logic [15:0] r_preset;
    logic        r_done;
    logic        r_err;
    logic [15:0] w_dec;
    logic        w_valid;
    logic        w_b0;
    logic        w_b1;
    logic        w_b2;
    logic        w_reload;
    assign w_valid = (data[15:12] <= 4'd5) && (data[11:8] <= 4'd9) &&
                     (data[7:4] <= 4'd5) && (data[3:0] <= 4'd9);
    // Borrow ripples upward only through digits that are already zero.
    assign w_b0 = (r_q[3:0] == 4'd0);
    assign w_b1 = w_b0 && (r_q[7:4] == 4'd0);
    assign w_b2 = w_b1 && (r_q[11:8] == 4'd0);
    assign w_dec[3:0]   = w_b0 ? 4'd9 : r_q[3:0] - 4'd1;
    assign w_dec[7:4]   = !w_b0 ? r_q[7:4] : (r_q[7:4] == 4'd0 ? 4'd5 : r_q[7:4] - 4'd1);
    assign w_dec[11:8]  = !w_b1 ? r_q[11:8] : (r_q[11:8] == 4'd0 ? 4'd9 : r_q[11:8] - 4'd1);
    assign w_dec[15:12] = !w_b2 ? r_q[15:12] : r_q[15:12] - 4'd1;
    assign w_reload = AUTO_RELOAD && (r_preset != 16'h0000);
    assign bout  = (r_state == RUN) & tick & (r_q == 16'h0001) & ~load & ~pause & ~reset;
    assign qout  = r_q;
    assign state = r_state;
    assign done  = r_done;
    assign err   = r_err;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= 16'h0000;
            r_preset <= 16'h0000;
            r_state  <= IDLE;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (load) begin
                if (w_valid) begin
                    r_q      <= data;
                    r_preset <= data;
                    r_state  <= IDLE;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (pause) begin
                if (r_state == RUN) r_state <= PAUSE;
            end else if (r_state == IDLE) begin
                if (start && r_q != 16'h0000) r_state <= RUN;
            end else if (r_state == PAUSE) begin
                if (start) r_state <= RUN;
            end else if (r_state == RUN && tick && r_q != 16'h0000) begin
                if (r_q == 16'h0001) begin
                    r_done  <= 1'b1;
                    r_q     <= w_reload ? r_preset : 16'h0000;
                    r_state <= w_reload ? RUN : DONE;
                end else begin
                    r_q <= w_dec;
                end
            end
        end
    end
endmodule
